// File: rtl/execute_stage.sv
// Execute stage: ALU, single-cycle signed multiply and a 32-iteration restoring
// divider. All results land in the EX/MEM register on the falling clock edge.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  inWB,
  input  logic [1:0]  inMEM,
  input  logic [3:0]  inALUCtrl,
  input  logic        inALUSrc,
  input  logic        inRegDst,
  input  logic [31:0] inRegA,
  input  logic [31:0] inRegB,
  input  logic [31:0] inSignExtImm,
  input  logic [4:0]  inShamt,
  input  logic [4:0]  inRt,
  input  logic [4:0]  inRd,
  input  logic        stop_debug,
  output logic [4:0]  outWB,
  output logic [1:0]  outMEM,
  output logic [31:0] outALUResult,
  output logic        outALUZero,
  output logic [31:0] outRegB,
  output logic [4:0]  outRegF_wreg,
  output logic        outStall
);

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpXor  = 4'd3;
  localparam logic [3:0] OpNor  = 4'd4;
  localparam logic [3:0] OpSltu = 4'd5;
  localparam logic [3:0] OpSub  = 4'd6;
  localparam logic [3:0] OpSlt  = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpLui  = 4'd11;
  localparam logic [3:0] OpMult = 4'd12;
  localparam logic [3:0] OpDiv  = 4'd13;
  localparam logic [3:0] OpMfhi = 4'd14;
  localparam logic [3:0] OpMflo = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  divState_t   divState;
  logic [4:0]  divCount;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] divRem;
  logic [31:0] divQuo;
  logic [31:0] divisor;
  logic [31:0] divDividend;
  logic        divSignA;
  logic        divSignB;
  logic        divZero;

  logic [31:0] opB;
  logic        isDiv;
  logic [63:0] product;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [32:0] remShift;
  logic [32:0] trial;
  logic        trialFits;
  logic [31:0] quoFixed;
  logic [31:0] remFixed;
  logic [31:0] divResultLo;
  logic [31:0] divResultHi;
  logic [31:0] aluResult;

  assign opB      = inALUSrc ? inSignExtImm : inRegB;
  assign isDiv    = (inALUCtrl == OpDiv);
  assign outStall = ((divState == IDLE) && isDiv) || (divState == BUSY);

  // Sign-extend to 64 bits first so the low 64 bits of the product are the signed result.
  assign product = $signed({{32{inRegA[31]}}, inRegA}) * $signed({{32{opB[31]}}, opB});

  assign absA = inRegA[31] ? -inRegA : inRegA;
  assign absB = opB[31] ? -opB : opB;

  // Restoring step: shift the next dividend bit in and subtract if it fits.
  assign remShift  = {divRem, divQuo[31]};
  assign trial     = remShift - {1'b0, divisor};
  assign trialFits = ~trial[32];

  assign quoFixed    = (divSignA ^ divSignB) ? -divQuo : divQuo;
  assign remFixed    = divSignA ? -divRem : divRem;
  assign divResultLo = divZero ? 32'hFFFF_FFFF : quoFixed;
  assign divResultHi = divZero ? divDividend : remFixed;

  always_comb begin
    aluResult = 32'd0;
    case (inALUCtrl)
      OpAnd:  aluResult = inRegA & opB;
      OpOr:   aluResult = inRegA | opB;
      OpAdd:  aluResult = inRegA + opB;
      OpXor:  aluResult = inRegA ^ opB;
      OpNor:  aluResult = ~(inRegA | opB);
      OpSltu: aluResult = {31'd0, (inRegA < opB)};
      OpSub:  aluResult = inRegA - opB;
      OpSlt:  aluResult = {31'd0, ($signed(inRegA) < $signed(opB))};
      OpSll:  aluResult = opB << inShamt;
      OpSrl:  aluResult = opB >> inShamt;
      OpSra:  aluResult = $signed(opB) >>> inShamt;
      OpLui:  aluResult = {opB[15:0], 16'h0000};
      OpMult: aluResult = product[31:0];
      OpDiv:  aluResult = divResultLo;
      OpMfhi: aluResult = hiReg;
      OpMflo: aluResult = loReg;
      default: aluResult = 32'd0;
    endcase
  end

  // Divider sequencing plus HI/LO ownership.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      divState    <= IDLE;
      divCount    <= 5'd0;
      hiReg       <= 32'd0;
      loReg       <= 32'd0;
      divRem      <= 32'd0;
      divQuo      <= 32'd0;
      divisor     <= 32'd0;
      divDividend <= 32'd0;
      divSignA    <= 1'b0;
      divSignB    <= 1'b0;
      divZero     <= 1'b0;
    end else if (!stop_debug) begin
      case (divState)
        IDLE: begin
          if (isDiv) begin
            divState    <= BUSY;
            divCount    <= 5'd0;
            divRem      <= 32'd0;
            divQuo      <= absA;
            divisor     <= absB;
            divDividend <= inRegA;
            divSignA    <= inRegA[31];
            divSignB    <= opB[31];
            divZero     <= (opB == 32'd0);
          end else if (inALUCtrl == OpMult) begin
            hiReg <= product[63:32];
            loReg <= product[31:0];
          end
        end
        BUSY: begin
          divRem   <= trialFits ? trial[31:0] : remShift[31:0];
          divQuo   <= {divQuo[30:0], trialFits};
          divCount <= divCount + 5'd1;
          if (divCount == 5'd31) begin
            divState <= DONE;
          end
        end
        DONE: begin
          hiReg    <= divResultHi;
          loReg    <= divResultLo;
          divState <= IDLE;
        end
        default: divState <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register; a stalled edge loads an all-zero bubble.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      outWB        <= 5'd0;
      outMEM       <= 2'd0;
      outALUResult <= 32'd0;
      outALUZero   <= 1'b0;
      outRegB      <= 32'd0;
      outRegF_wreg <= 5'd0;
    end else if (!stop_debug) begin
      if (outStall) begin
        outWB        <= 5'd0;
        outMEM       <= 2'd0;
        outALUResult <= 32'd0;
        outALUZero   <= 1'b0;
        outRegB      <= 32'd0;
        outRegF_wreg <= 5'd0;
      end else begin
        outWB        <= inWB;
        outMEM       <= inMEM;
        outALUResult <= aluResult;
        outALUZero   <= (aluResult == 32'd0);
        outRegB      <= inRegB;
        outRegF_wreg <= inRegDst ? inRd : inRt;
      end
    end
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  in  1  pipeline clock; all stage registers update on its falling edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 inWB  in  5  writeback control, passed through to outWB.
REQ-004 inMEM  in  2  memory control, passed through to outMEM.
REQ-005 inALUCtrl  in  4  operation select (encoding in REQ-020).
REQ-006 inALUSrc  in  1  1 = operand B is inSignExtImm; 0 = inRegB.
REQ-007 inRegDst  in  1  1 = destination is inRd; 0 = inRt.
REQ-008 inRegA, inRegB, inSignExtImm  in  32 each  operands.
REQ-009 inShamt, inRt, inRd  in  5 each  shift amount and register numbers.
REQ-010 stop_debug  in  1  debug freeze.
REQ-011 outWB  out  5; outMEM  out  2; outALUResult  out  32; outALUZero  out  1; outRegB  out  32; outRegF_wreg  out  5. All are registered (EX/MEM register).
REQ-012 outStall  out  1  combinational; 1 = upstream SHALL hold its inputs stable.

Function
REQ-020 inALUCtrl encoding:
- 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLTU, 6 SUB, 7 SLT
- 8 SLL, 9 SRL, 10 SRA (shift inB by inShamt)
- 11 LUI ({B[15:0],16'h0})
- 12 MULT, 13 DIV, 14 MFHI, 15 MFLO
REQ-021 ADD and SUB wrap modulo 2^32; no overflow trap.
REQ-022 SLT compares signed; SLTU compares unsigned; result is 0 or 1.
REQ-023 When not stalled and not frozen, each falling edge captures:
- outWB, outMEM, outRegF_wreg (selected per REQ-007);
- outRegB = inRegB;
- outALUResult = op result;
- outALUZero = (op result == 0).
REQ-024 MULT: signed 32x32 -> 64-bit product; {HI,LO} written at the capture edge (single cycle); outALUResult = LO.
REQ-025 MFHI and MFLO return HI/LO as updated by every prior retired MULT/DIV; no hazard window.
REQ-026 Divider FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY on a falling edge where inALUCtrl==13 and !stop_debug; this latches |A|, |B| and the sign flags, and clears the count.
REQ-027 BUSY performs one restoring-division iteration per edge; after exactly 32 iterations it goes to DONE.
REQ-028 DONE:
- LO = quotient; HI = remainder, sign-corrected (quotient negative iff sign(A) xor sign(B); remainder takes sign(A));
- EX/MEM captures the DIV instruction normally (outALUResult = quotient);
- next state is IDLE.
REQ-029 outStall = (IDLE and inALUCtrl==13) or BUSY. A DIV therefore stalls for 33 cycles and retires on the 34th edge.
REQ-030 On every edge while outStall=1, EX/MEM loads a bubble: outWB=0, outMEM=0, outRegF_wreg=0, outALUResult=0, outRegB=0, outALUZero=0.
REQ-031 Divide by zero: LO=32'hFFFFFFFF, HI=inRegA. Latency is unchanged.
REQ-032 Signed corner case: 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0.
REQ-033 stop_debug=1 freezes everything: EX/MEM register, FSM state, iteration count, HI, LO. outStall stays a function of the frozen state.

Reset
REQ-040 rst low asynchronously sets:
- all outputs of REQ-011 to 0;
- HI=0, LO=0;
- FSM to IDLE, count to 0.
REQ-041 rst asserted mid-division aborts it; HI and LO read 0 afterwards; outStall falls immediately unless inALUCtrl==13.
REQ-042 rst released with inputs idle gives outStall=0.

Verification
REQ-050 ADD A=7FFFFFFF, B=1 -> outALUResult=80000000, outALUZero=0. SUB A=B=5 -> result 0, outALUZero=1.
REQ-051 SRA inB=F0000000, inShamt=4 -> FF000000. LUI imm=1234 -> 12340000. RegDst=1, Rd=9 -> outRegF_wreg=9.
REQ-052 MULT A=FFFFFFFE(-2), B=3 -> HI=FFFFFFFF, LO=FFFFFFFA; the next MFHI returns FFFFFFFF.
REQ-053 DIV A=-7, B=2 -> outStall high 33 cycles, 33 bubble captures, then LO=FFFFFFFD, HI=FFFFFFFF. DIV by 0 -> LO=FFFFFFFF, HI=A.
REQ-054 Toggle stop_debug for 5 cycles mid-DIV -> completion delayed by exactly 5 cycles; result unchanged.
REQ-055 rst low at DIV iteration 10 -> all outputs 0, FSM IDLE, HI=LO=0; a following MFLO returns 0.
